// File: rtl/shift_univ.sv
// shift_univ: parametrised universal shift register with a burst engine.
//
// Manual mode (IDLE, en=1): each edge performs the operation on mode
//   00 hold, 01 shift left, 10 shift right, 11 parallel load.
// Burst mode: a start pulse with mode 01/10 and non-zero burst_len launches
//   min(burst_len, WIDTH) shifts in the latched direction, then pulses done.
//
// Ports:
//   clk        system clock, rising-edge
//   rst        synchronous reset, active-low
//   en         manual operation enable (IDLE only)
//   mode       operation select
//   din        serial input bit
//   pdata      parallel load data
//   start      burst request (IDLE only)
//   burst_len  requested number of burst shifts
//   q          register contents
//   sout_l     q[WIDTH-1], bit leaving on a left shift
//   sout_r     q[0], bit leaving on a right shift
//   busy       burst in progress
//   done       one-cycle burst completion pulse
module shift_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir_right, dir_right_nxt;
  logic             busy_nxt, done_nxt;
  logic             req_valid;
  logic [WIDTH-1:0] q_left, q_right;

  assign sout_l  = q[WIDTH-1];
  assign sout_r  = q[0];
  assign q_left  = {q[WIDTH-2:0], din};
  assign q_right = {din, q[WIDTH-1:1]};

  // Only a real shift direction with a non-zero length can launch a burst.
  assign req_valid = start && (mode == MODE_LEFT || mode == MODE_RIGHT)
                     && (burst_len != '0);

  // State register; reset wins over everything, so an aborted burst
  // never produces a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      q         <= '0;
      cnt       <= '0;
      dir_right <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      q         <= q_nxt;
      cnt       <= cnt_nxt;
      dir_right <= dir_right_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic. A valid start takes priority over the manual
  // operation and leaves q untouched on its accepting edge.
  always_comb begin
    state_nxt     = state;
    q_nxt         = q;
    cnt_nxt       = cnt;
    dir_right_nxt = dir_right;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          dir_right_nxt = (mode == MODE_RIGHT);
          cnt_nxt       = (burst_len > CNT_MAX) ? CNT_MAX : burst_len;
          busy_nxt      = 1'b1;
          state_nxt     = SHIFT;
        end else if (en) begin
          unique case (mode)
            MODE_HOLD:  q_nxt = q;
            MODE_LEFT:  q_nxt = q_left;
            MODE_RIGHT: q_nxt = q_right;
            MODE_LOAD:  q_nxt = pdata;
            default:    q_nxt = q;
          endcase
        end
      end
      SHIFT: begin
        q_nxt   = dir_right ? q_right : q_left;
        cnt_nxt = cnt - 1'b1;
        // The <= guard keeps a corrupted zero count from wrapping.
        if (cnt <= 1) begin
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_univ.sv
// tb_shift_univ: directed self-checking bench for shift_univ.
// Instantiates an 8-bit register and a 4-bit register sharing clock and reset.
module tb_shift_univ;

  logic       clk = 1'b0;
  logic       rst;

  logic       en, din, start;
  logic [1:0] mode;
  logic [7:0] pdata;
  logic [3:0] burst_len;
  logic [7:0] q;
  logic       sout_l, sout_r, busy, done;

  logic       en4, din4, start4;
  logic [1:0] mode4;
  logic [3:0] pdata4;
  logic [2:0] burst_len4;
  logic [3:0] q4;
  logic       sout_l4, sout_r4, busy4, done4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_univ #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din), .pdata(pdata),
    .start(start), .burst_len(burst_len), .q(q), .sout_l(sout_l),
    .sout_r(sout_r), .busy(busy), .done(done)
  );

  shift_univ #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .din(din4), .pdata(pdata4),
    .start(start4), .burst_len(burst_len4), .q(q4), .sout_l(sout_l4),
    .sout_r(sout_r4), .busy(busy4), .done(done4)
  );

  // Advance one rising edge and settle 1ns past it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (q4 !== 4'h0) begin errors++; $display("[TB] FAIL rst_q4 got %h exp 0", q4); end
      checks++; if (q !== 8'h00) begin errors++; $display("[TB] FAIL rst_q got %h exp 00", q); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags got busy=%b done=%b exp 0/0", busy, done); end
    end
    rst = 1'b1;
  endtask

  task automatic test_manual_left4();
    logic [3:0] exp_q [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
    en4 = 1'b1; mode4 = 2'b01; din4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (q4 !== exp_q[i]) begin errors++; $display("[TB] FAIL left4_q%0d got %h exp %h", i, q4, exp_q[i]); end
    end
    checks++; if (sout_l4 !== 1'b1) begin errors++; $display("[TB] FAIL left4_sout_l got %b exp 1", sout_l4); end
    en4 = 1'b0;
  endtask

  task automatic test_load_right();
    logic [7:0] exp_q [3] = '{8'h52, 8'h29, 8'h14};
    logic       exp_r [3] = '{1'b0, 1'b1, 1'b0};
    en = 1'b1; mode = 2'b11; pdata = 8'hA5;
    step();
    checks++; if (q !== 8'hA5) begin errors++; $display("[TB] FAIL load_q got %h exp a5", q); end
    checks++; if (sout_r !== 1'b1) begin errors++; $display("[TB] FAIL load_sout_r got %b exp 1", sout_r); end
    mode = 2'b10; din = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (q !== exp_q[i]) begin errors++; $display("[TB] FAIL right_q%0d got %h exp %h", i, q, exp_q[i]); end
      checks++; if (sout_r !== exp_r[i]) begin errors++; $display("[TB] FAIL right_sout_r%0d got %b exp %b", i, sout_r, exp_r[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_burst_left();
    logic [7:0] exp_q [3] = '{8'h02, 8'h04, 8'h08};
    en = 1'b1; mode = 2'b11; pdata = 8'h81;
    step();
    checks++; if (sout_l !== 1'b1) begin errors++; $display("[TB] FAIL burst_pre_sout_l got %b exp 1", sout_l); end
    en = 1'b0; start = 1'b1; mode = 2'b01; burst_len = 4'd3; din = 1'b0;
    step();
    checks++; if (busy !== 1'b1 || q !== 8'h81) begin errors++; $display("[TB] FAIL burst_accept got busy=%b q=%h exp 1/81", busy, q); end
    // Manual controls wiggle during the burst and must be ignored.
    start = 1'b0; en = 1'b1; mode = 2'b11; pdata = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      mode = (i % 2 == 0) ? 2'b10 : 2'b11;
      checks++; if (q !== exp_q[i]) begin errors++; $display("[TB] FAIL burst_q%0d got %h exp %h", i, q, exp_q[i]); end
      checks++; if (busy !== (i < 2)) begin errors++; $display("[TB] FAIL burst_busy%0d got %b exp %b", i, busy, (i < 2)); end
      checks++; if (done !== (i == 2)) begin errors++; $display("[TB] FAIL burst_done%0d got %b exp %b", i, done, (i == 2)); end
    end
    checks++; if (sout_l !== 1'b0) begin errors++; $display("[TB] FAIL burst_sout_l got %b exp 0", sout_l); end
    en = 1'b0; mode = 2'b00;
    step();
    checks++; if (done !== 1'b0 || q !== 8'h08) begin errors++; $display("[TB] FAIL burst_after got done=%b q=%h exp 0/08", done, q); end
  endtask

  task automatic test_invalid_clamp();
    en = 1'b0; start = 1'b1; mode = 2'b01; burst_len = 4'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL zero_len%0d got busy=%b done=%b exp 0/0", i, busy, done); end
    end
    start = 1'b0; en = 1'b1; mode = 2'b11; pdata = 8'h00;
    step();
    en = 1'b0; start = 1'b1; mode = 2'b10; burst_len = 4'd15; din = 1'b1;
    step();
    checks++; if (busy !== 1'b1 || q !== 8'h00) begin errors++; $display("[TB] FAIL clamp_accept got busy=%b q=%h exp 1/00", busy, q); end
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++; if (q !== 8'hFE || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL clamp_7th got q=%h busy=%b done=%b exp fe/1/0", q, busy, done); end
    step();
    checks++; if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL clamp_8th got q=%h busy=%b done=%b exp ff/0/1", q, busy, done); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL clamp_after got done=%b exp 0", done); end
  endtask

  task automatic test_reset_mid_burst();
    int seen_done = 0;
    start = 1'b1; mode = 2'b01; burst_len = 4'd8; din = 1'b0; en = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy4 got %b exp 1", busy); end
    rst = 1'b0;
    step();
    checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midrst got q=%h busy=%b done=%b exp 00/0/0", q, busy, done); end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1 || busy !== 1'b0) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("[TB] FAIL midrst_tail got %0d cycles with done/busy exp 0", seen_done); end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; mode = 2'b11; pdata = 8'h01;
    step();
    en = 1'b0; start = 1'b1; mode = 2'b01; burst_len = 4'd2; din = 1'b0;
    step();
    start = 1'b0;
    step();
    checks++; if (q !== 8'h02) begin errors++; $display("[TB] FAIL b2b_a_q1 got %h exp 02", q); end
    step();
    checks++; if (q !== 8'h04 || done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_a_done got q=%h done=%b exp 04/1", q, done); end
    start = 1'b1; mode = 2'b10; burst_len = 4'd2;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b1 || q !== 8'h04) begin errors++; $display("[TB] FAIL b2b_b_accept got done=%b busy=%b q=%h exp 0/1/04", done, busy, q); end
    start = 1'b0;
    step(); step();
    checks++; if (q !== 8'h01 || done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_b_done got q=%h done=%b exp 01/1", q, done); end
    start = 1'b0;
    step();
    // Start together with a manual left shift: start wins, q stays put.
    start = 1'b1; en = 1'b1; mode = 2'b01; burst_len = 4'd1; din = 1'b1;
    step();
    checks++; if (q !== 8'h01 || busy !== 1'b1) begin errors++; $display("[TB] FAIL prio_accept got q=%h busy=%b exp 01/1", q, busy); end
    start = 1'b0; en = 1'b0;
    step();
    checks++; if (q !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL prio_done got q=%h done=%b busy=%b exp 03/1/0", q, done, busy); end
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0; din = 1'b0; start = 1'b0; mode = 2'b00; pdata = '0; burst_len = '0;
    en4 = 1'b0; din4 = 1'b0; start4 = 1'b0; mode4 = 2'b00; pdata4 = '0; burst_len4 = '0;
    #1;
    $display("[TB] starting shift_univ bench");
    test_reset();
    test_manual_left4();
    test_load_right();
    test_burst_left();
    test_invalid_clamp();
    test_reset_mid_burst();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_univ.md
Name: shift_univ

Overview:
- Parametrised universal shift register. Successor to the fixed 4-bit serial-in shift register.
- Adds per-cycle hold, shift-left, shift-right and parallel-load modes.
- Adds a burst engine that performs a programmed number of shifts under a start/busy/done handshake.
- Used as the serialiser/deserialiser primitive for LED chains and simple serial links on the MAX10 board.

Parameters:
- WIDTH, 8, register width in bits (must be at least 2).
- CNT_W, $clog2(WIDTH)+1, width of burst_len. It must be able to hold the value WIDTH.

Ports:
- clk  in  1  system clock. All logic updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- en  in  1  enables the manual operation selected by mode. Sampled only in IDLE.
- mode  in  2  operation select: 00 = hold, 01 = shift left, 10 = shift right, 11 = parallel load.
- din  in  1  serial input bit.
- pdata  in  WIDTH  parallel load data.
- start  in  1  burst request. One-cycle pulse or level; it is sampled only in IDLE.
- burst_len  in  CNT_W  number of shifts in the burst.
- q  out  WIDTH  register contents (registered).
- sout_l  out  1  equals q[WIDTH-1]. This is the bit shifted out by a left shift.
- sout_r  out  1  equals q[0]. This is the bit shifted out by a right shift.
- busy  out  1  high while a burst is in progress (registered).
- done  out  1  one-cycle pulse when a burst completes (registered).

Behaviour:
- Reset: when rst=0 at a rising edge, the following hold after that edge:
  - q=0, busy=0, done=0.
  - FSM in IDLE, remaining-shift counter = 0, latched direction = left.
  - Reset overrides every other input, including during a burst. An aborted burst produces no done pulse.
- Shift semantics:
  - Left: q <= {q[WIDTH-2:0], din}.
  - Right: q <= {din, q[WIDTH-1:1]}.
  - Load: q <= pdata.
  - Hold: q unchanged.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 with a valid request:
  - A valid request means mode is 01 or 10 and burst_len is non-zero.
  - At that edge: latch the direction from mode, counter <= min(burst_len, WIDTH), busy <= 1, go to SHIFT.
  - q is NOT modified at this edge.
- IDLE, start=1 with an invalid request (mode 00/11 or burst_len=0): start is ignored. Manual operation proceeds per en/mode.
- IDLE, start=0:
  - en=1: perform the mode operation each edge.
  - en=0: hold q.
  - done <= 0.
- IDLE, start=1 with a valid request and en=1: start has priority. The manual op is not performed on that edge.
- SHIFT, each edge:
  - Shift q once in the latched direction using the current din.
  - Counter decrements.
  - en, mode, start, pdata and burst_len are ignored.
- SHIFT, counter=1 at an edge: perform the final shift, busy <= 0, done <= 1, go to IDLE.
- Burst timing: a burst of N shifts occupies edges k+1..k+N, where k is the edge that accepted start.
  - busy is high from after edge k until after edge k+N.
  - done is high for exactly the cycle after edge k+N.
  - Total latency from the start edge to done is N+1 edges.
- Back-to-back bursts: start may be asserted in the cycle where done=1. It is accepted because the FSM is in IDLE. done then drops on the next edge and busy rises.
- Clamping: burst_len > WIDTH is clamped to WIDTH. The counter never wraps.
- sout_l and sout_r are combinational views of q. They have no extra latency.

Test Plan:
1. Reset and manual left shift (WIDTH=4):
   - Stimulus: hold rst=0 for 2 edges, then rst=1, en=1, mode=01, din=1.
   - Required: q=0000 during reset, then 0001, 0011, 0111, 1111 on successive edges.
2. Parallel load then right shift (WIDTH=8):
   - Stimulus: mode=11, pdata=8'hA5, en=1 for 1 edge; then mode=10, din=0 for 3 edges.
   - Required: q=A5, 52, 29, 14. sout_r follows q[0]: 1, 0, 1, 0.
3. Burst left (WIDTH=8):
   - Stimulus: from q=8'h81, start=1, mode=01, burst_len=3, din=0.
   - Required: busy=1 for 3 cycles. q=02, 04, 08. done=1 for exactly one cycle after the 3rd shift, then 0.
   - en/mode toggling during busy has no effect.
4. Invalid and clamped requests (WIDTH=8):
   - burst_len=0 with start=1: busy stays 0 and no done pulse.
   - burst_len=15, mode=10, din=1, q=00: exactly 8 shifts; q=FF when done=1.
5. Reset mid-burst:
   - Stimulus: start a burst with burst_len=8, then drive rst=0 at the 4th busy cycle.
   - Required: next cycle q=0, busy=0, done=0, and no done pulse follows.
6. Back-to-back and priority:
   - Stimulus: assert start in the done cycle with burst_len=2; separately, in IDLE assert start together with en=1, mode=01.
   - Required: the second burst runs immediately (done → busy transition). On the start edge, q does not shift.
